call_return_ctrl: RTL and testbench

- Processor-side master of the 8-bit return-address stack.
- On CALL, pushes a PC_WIDTH-bit return address as two bytes (low byte, then high byte), then issues a jump to the call target.
- On RET, pops two bytes (high byte, then low byte), reassembles the address and issues a PC load.
- Tracks occupancy internally and flags overflow and underflow, so the stack never wraps.

---
 rtl/call_return_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_call_return_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/call_return_ctrl.sv
// call_return_ctrl: processor-side master of an 8-bit return-address stack.
// A CALL pushes the return address (low byte, then high byte) and loads the
// call target into pc_out. A RET pops two bytes (high, then low) and loads
// the reassembled address. Occupancy is tracked internally so the stack is
// never pushed past MAX_FRAMES frames or popped when empty.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   call_req, ret_req    requests, sampled in IDLE only (CALL has priority)
//   ret_addr_in          return address saved on CALL
//   call_target          jump destination on CALL
//   busy                 high in every state except IDLE
//   pc_load, pc_out      one-cycle load pulse and the address it carries
//   overflow, underflow  one-cycle pulses for rejected CALL / RET
//   frames               number of saved return addresses
//   stk_push, stk_pop    stack strobes (never both high)
//   stk_wdata            byte to push
//   stk_rdata            stack top, valid the cycle after a pop strobe
module call_return_ctrl #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned STACK_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                call_req,
    input  logic                ret_req,
    input  logic [PC_WIDTH-1:0] ret_addr_in,
    input  logic [PC_WIDTH-1:0] call_target,
    output logic                busy,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                overflow,
    output logic                underflow,
    output logic [4:0]          frames,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [7:0]          stk_wdata,
    input  logic [7:0]          stk_rdata
);

    localparam int unsigned MAX_FRAMES = (STACK_DEPTH - 1) / 2;
    localparam int unsigned HI_W       = PC_WIDTH - 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_LO = 3'd1,
        PUSH_HI = 3'd2,
        POP_HI  = 3'd3,
        POP_LO  = 3'd4,
        POP_CAP = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t              r_state;
    logic [HI_W-1:0]     r_addr_hi;
    logic [PC_WIDTH-1:0] r_target;
    logic [7:0]          r_pop_hi;
    logic [4:0]          r_frames;
    logic [PC_WIDTH-1:0] r_pc_out;
    logic [7:0]          r_stk_wdata;
    logic                r_busy;
    logic                r_pc_load;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_stk_push;
    logic                r_stk_pop;

    state_t              w_state_nxt;
    logic [HI_W-1:0]     w_addr_hi_nxt;
    logic [PC_WIDTH-1:0] w_target_nxt;
    logic [7:0]          w_pop_hi_nxt;
    logic [4:0]          w_frames_nxt;
    logic [PC_WIDTH-1:0] w_pc_out_nxt;
    logic [7:0]          w_stk_wdata_nxt;
    logic                w_overflow_nxt;
    logic                w_underflow_nxt;

    // Next-state and datapath updates; pc_out and frames change on entry to DONE
    // so they are already valid during the pc_load cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_hi_nxt   = r_addr_hi;
        w_target_nxt    = r_target;
        w_pop_hi_nxt    = r_pop_hi;
        w_frames_nxt    = r_frames;
        w_pc_out_nxt    = r_pc_out;
        w_stk_wdata_nxt = r_stk_wdata;
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (call_req) begin
                    if (r_frames < 5'(MAX_FRAMES)) begin
                        w_addr_hi_nxt   = ret_addr_in[PC_WIDTH-1:8];
                        w_target_nxt    = call_target;
                        w_stk_wdata_nxt = ret_addr_in[7:0];
                        w_state_nxt     = PUSH_LO;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                end else if (ret_req) begin
                    if (r_frames != 5'd0) begin
                        w_state_nxt = POP_HI;
                    end else begin
                        w_underflow_nxt = 1'b1;
                    end
                end
            end
            PUSH_LO: begin
                w_stk_wdata_nxt = 8'(r_addr_hi);
                w_state_nxt     = PUSH_HI;
            end
            PUSH_HI: begin
                w_pc_out_nxt = r_target;
                w_frames_nxt = r_frames + 5'd1;
                w_state_nxt  = DONE;
            end
            POP_HI: begin
                w_state_nxt = POP_LO;
            end
            POP_LO: begin
                // First popped byte is on stk_rdata now
                w_pop_hi_nxt = stk_rdata;
                w_state_nxt  = POP_CAP;
            end
            POP_CAP: begin
                w_pc_out_nxt = PC_WIDTH'({r_pop_hi, stk_rdata});
                w_frames_nxt = r_frames - 5'd1;
                w_state_nxt  = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; strobes are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr_hi   <= '0;
            r_target    <= '0;
            r_pop_hi    <= '0;
            r_frames    <= '0;
            r_pc_out    <= '0;
            r_stk_wdata <= '0;
            r_busy      <= 1'b0;
            r_pc_load   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_stk_push  <= 1'b0;
            r_stk_pop   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_hi   <= w_addr_hi_nxt;
            r_target    <= w_target_nxt;
            r_pop_hi    <= w_pop_hi_nxt;
            r_frames    <= w_frames_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_stk_wdata <= w_stk_wdata_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_pc_load   <= (w_state_nxt == DONE);
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
            r_stk_push  <= (w_state_nxt == PUSH_LO) || (w_state_nxt == PUSH_HI);
            r_stk_pop   <= (w_state_nxt == POP_HI) || (w_state_nxt == POP_LO);
        end
    end

    assign busy      = r_busy;
    assign pc_load   = r_pc_load;
    assign pc_out    = r_pc_out;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign frames    = r_frames;
    assign stk_push  = r_stk_push;
    assign stk_pop   = r_stk_pop;
    assign stk_wdata = r_stk_wdata;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural byte stack attached.
module tb_call_return_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        call_req;
    logic        ret_req;
    logic [15:0] ret_addr_in;
    logic [15:0] call_target;
    logic        busy;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        overflow;
    logic        underflow;
    logic [4:0]  frames;
    logic        stk_push;
    logic        stk_pop;
    logic [7:0]  stk_wdata;
    logic [7:0]  stk_rdata;

    int checks = 0;
    int errors = 0;

    call_return_ctrl #(.PC_WIDTH(16), .STACK_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .ret_addr_in(ret_addr_in), .call_target(call_target),
        .busy(busy), .pc_load(pc_load), .pc_out(pc_out),
        .overflow(overflow), .underflow(underflow), .frames(frames),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata)
    );

    always #5 clk = ~clk;

    // Byte stack: read data is the popped byte, registered on the pop edge.
    logic [7:0] mem [32];
    int         sp;
    logic       model_err;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= 0;
            stk_rdata <= 8'h00;
            model_err <= 1'b0;
        end else begin
            if (stk_push && stk_pop) model_err <= 1'b1;
            if (stk_push) begin
                if (sp >= 31) model_err <= 1'b1;
                else begin
                    mem[sp[4:0]] <= stk_wdata;
                    sp           <= sp + 1;
                end
            end else if (stk_pop) begin
                if (sp == 0) model_err <= 1'b1;
                else begin
                    stk_rdata <= mem[5'(sp - 1)];
                    sp        <= sp - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [15:0] addr, input logic [15:0] tgt,
                           input logic [4:0] exp_frames, input string tag);
        call_req    = 1'b1;
        ret_addr_in = addr;
        call_target = tgt;
        step();
        checks++; if (stk_push !== 1'b1 || stk_wdata !== addr[7:0] || busy !== 1'b1) begin errors++; $display("FAIL %s push_lo push=%b wdata=%h busy=%b exp 1/%h/1", tag, stk_push, stk_wdata, busy, addr[7:0]); end
        step();
        checks++; if (stk_push !== 1'b1 || stk_wdata !== addr[15:8] || pc_load !== 1'b0) begin errors++; $display("FAIL %s push_hi push=%b wdata=%h load=%b exp 1/%h/0", tag, stk_push, stk_wdata, pc_load, addr[15:8]); end
        step();
        checks++; if (pc_load !== 1'b1 || pc_out !== tgt || frames !== exp_frames || stk_push !== 1'b0) begin errors++; $display("FAIL %s call_load load=%b pc=%h frames=%0d push=%b exp 1/%h/%0d/0", tag, pc_load, pc_out, frames, stk_push, tgt, exp_frames); end
        call_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("FAIL %s call_idle busy=%b load=%b exp 0/0", tag, busy, pc_load); end
    endtask

    task automatic do_ret(input logic [15:0] exp_pc, input logic [4:0] exp_frames, input string tag);
        ret_req = 1'b1;
        step();
        checks++; if (stk_pop !== 1'b1 || stk_push !== 1'b0) begin errors++; $display("FAIL %s pop1 pop=%b push=%b exp 1/0", tag, stk_pop, stk_push); end
        step();
        checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL %s pop2 pop=%b exp 1", tag, stk_pop); end
        step();
        checks++; if (stk_pop !== 1'b0 || pc_load !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s pop_cap pop=%b load=%b busy=%b exp 0/0/1", tag, stk_pop, pc_load, busy); end
        step();
        checks++; if (pc_load !== 1'b1 || pc_out !== exp_pc || frames !== exp_frames) begin errors++; $display("FAIL %s ret_load load=%b pc=%h frames=%0d exp 1/%h/%0d", tag, pc_load, pc_out, frames, exp_pc, exp_frames); end
        ret_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("FAIL %s ret_idle busy=%b load=%b exp 0/0", tag, busy, pc_load); end
    endtask

    task automatic test_reset();
        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0;
        ret_addr_in = 16'h0000; call_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, pc_load, overflow, underflow, stk_push, stk_pop} !== 6'b0 || pc_out !== 16'h0 || frames !== 5'd0 || stk_wdata !== 8'h00) begin errors++; $display("FAIL reset_state flags=%b pc=%h frames=%0d wdata=%h exp all 0", {busy, pc_load, overflow, underflow, stk_push, stk_pop}, pc_out, frames, stk_wdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_call_ret();
        do_call(16'h1234, 16'h0800, 5'd1, "call_1234");
        checks++; if (sp !== 2) begin errors++; $display("FAIL call_depth sp=%0d exp 2", sp); end
        do_ret(16'h1234, 5'd0, "ret_1234");
    endtask

    task automatic test_nested();
        do_call(16'h0101, 16'h0A01, 5'd1, "nest_c1");
        do_call(16'h0202, 16'h0A02, 5'd2, "nest_c2");
        do_call(16'h0303, 16'h0A03, 5'd3, "nest_c3");
        do_ret(16'h0303, 5'd2, "nest_r3");
        do_ret(16'h0202, 5'd1, "nest_r2");
        do_ret(16'h0101, 5'd0, "nest_r1");
    endtask

    task automatic test_capacity();
        for (int i = 0; i < 15; i++)
            do_call(16'h1000 + 16'(i) * 16'h0111, 16'h2000 + 16'(i), 5'(i + 1), "cap_call");
        call_req = 1'b1; ret_addr_in = 16'hBEEF; call_target = 16'hCAFE;
        step();
        checks++; if (overflow !== 1'b1 || stk_push !== 1'b0 || busy !== 1'b0 || frames !== 5'd15) begin errors++; $display("FAIL overflow_pulse ovf=%b push=%b busy=%b frames=%0d exp 1/0/0/15", overflow, stk_push, busy, frames); end
        call_req = 1'b0;
        step();
        checks++; if (overflow !== 1'b0 || stk_push !== 1'b0 || frames !== 5'd15 || sp !== 30) begin errors++; $display("FAIL overflow_after ovf=%b push=%b frames=%0d sp=%0d exp 0/0/15/30", overflow, stk_push, frames, sp); end
        for (int i = 14; i >= 0; i--)
            do_ret(16'h1000 + 16'(i) * 16'h0111, 5'(i), "cap_ret");
        ret_req = 1'b1;
        step();
        checks++; if (underflow !== 1'b1 || stk_pop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL underflow_pulse unf=%b pop=%b busy=%b exp 1/0/0", underflow, stk_pop, busy); end
        ret_req = 1'b0;
        step();
        checks++; if (underflow !== 1'b0 || stk_pop !== 1'b0 || frames !== 5'd0) begin errors++; $display("FAIL underflow_after unf=%b pop=%b frames=%0d exp 0/0/0", underflow, stk_pop, frames); end
    endtask

    task automatic test_priority();
        // Both requests with an empty stack: CALL wins, no underflow
        call_req = 1'b1; ret_req = 1'b1;
        ret_addr_in = 16'h4567; call_target = 16'h0900;
        step();
        checks++; if (stk_push !== 1'b1 || stk_pop !== 1'b0 || underflow !== 1'b0 || stk_wdata !== 8'h67) begin errors++; $display("FAIL prio_start push=%b pop=%b unf=%b wdata=%h exp 1/0/0/67", stk_push, stk_pop, underflow, stk_wdata); end
        step();
        step();
        checks++; if (pc_load !== 1'b1 || pc_out !== 16'h0900 || frames !== 5'd1) begin errors++; $display("FAIL prio_load load=%b pc=%h frames=%0d exp 1/0900/1", pc_load, pc_out, frames); end
        call_req = 1'b0; ret_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || stk_pop !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL prio_idle busy=%b pop=%b unf=%b exp 0/0/0", busy, stk_pop, underflow); end
        // ret_req raised mid-CALL is ignored
        call_req = 1'b1; ret_addr_in = 16'h89AB; call_target = 16'h0A00;
        step();
        ret_req = 1'b1;
        step();
        step();
        checks++; if (pc_load !== 1'b1 || pc_out !== 16'h0A00 || frames !== 5'd2) begin errors++; $display("FAIL busy_ret_load load=%b pc=%h frames=%0d exp 1/0A00/2", pc_load, pc_out, frames); end
        call_req = 1'b0; ret_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || stk_pop !== 1'b0 || frames !== 5'd2) begin errors++; $display("FAIL busy_ret_idle busy=%b pop=%b frames=%0d exp 0/0/2", busy, stk_pop, frames); end
        do_ret(16'h89AB, 5'd1, "prio_r2");
        do_ret(16'h4567, 5'd0, "prio_r1");
    endtask

    task automatic test_mid_reset();
        do_call(16'h5555, 16'h0B00, 5'd1, "mr_pre");
        call_req = 1'b1; ret_addr_in = 16'h7777; call_target = 16'h0C00;
        step();
        step();
        checks++; if (stk_push !== 1'b1 || stk_wdata !== 8'h77 || busy !== 1'b1) begin errors++; $display("FAIL mr_push_hi push=%b wdata=%h busy=%b exp 1/77/1", stk_push, stk_wdata, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || stk_push !== 1'b0 || frames !== 5'd0 || pc_load !== 1'b0) begin errors++; $display("FAIL mr_async busy=%b push=%b frames=%0d load=%b exp 0/0/0/0", busy, stk_push, frames, pc_load); end
        call_req = 1'b0;
        step();
        rst = 1'b0;
        checks++; if (pc_load !== 1'b0 || pc_out !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL mr_held load=%b pc=%h busy=%b exp 0/0000/0", pc_load, pc_out, busy); end
        step();
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL mr_no_load load=%b exp 0", pc_load); end
        do_call(16'h00AA, 16'h0400, 5'd1, "mr_call");
        do_ret(16'h00AA, 5'd0, "mr_ret");
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_nested();
        test_capacity();
        test_priority();
        test_mid_reset();
        checks++; if (model_err !== 1'b0 || sp !== 0) begin errors++; $display("FAIL stack_model err=%b sp=%0d exp 0/0", model_err, sp); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
